// File: rtl/debug_trigger_unit.sv
// debug_trigger_unit
//   Free-running cycle counter with NCH cycle-compare trigger channels, a
//   RUN/HALTED/STEP halt state machine, a sticky ebreak flag and a host
//   register window on the coprocessor IO bus.
// Ports
//   clk, reset            core clock, async active-high reset
//   debugEnable           0: triggers/ebreak-halt ignored, forced RUN, host writes dropped
//   hostWrite             host write strobe for coprocessorIOAddr
//   hostFreeze            host memory access in progress; stalls core and counter
//   coprocessorIOAddr     host register address (decoded when bit 12 = 1)
//   coprocessorIODataOut  host write data
//   coprocessorIODataIn   registered host read data (1-cycle latency, post-update)
//   ebreakSignal          EBREAK decoded pulse
//   coreStall             pipeline stall
//   cycleCount            current counter value
//   haltedFlag            state is HALTED
//   debugFlags            {channel hit sticky[NCH-1:0], ebreak sticky}
// CTRL reads {haltOnEbreak, state}; state encoding RUN=0, HALTED=1, STEP=2.
module debug_trigger_unit #(
  parameter int unsigned N   = 64,
  parameter int unsigned NCH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         debugEnable,
  input  logic         hostWrite,
  input  logic         hostFreeze,
  input  logic [14:0]  coprocessorIOAddr,
  input  logic [N-1:0] coprocessorIODataOut,
  output logic [N-1:0] coprocessorIODataIn,
  input  logic         ebreakSignal,
  output logic         coreStall,
  output logic [N-1:0] cycleCount,
  output logic         haltedFlag,
  output logic [NCH:0] debugFlags
);

  localparam int unsigned FW = NCH + 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } haltState_e;

  haltState_e   state, stateNext;
  logic         haltOnEbreak, haltOnEbreakNext;
  logic [NCH:0] status, statusNext;
  logic [N-1:0] cycleNext;
  logic [N-1:0] compareReg [NCH];
  logic [N-1:0] compareNext [NCH];
  logic [N-1:0] periodReg [NCH];
  logic [N-1:0] periodNext [NCH];
  logic [1:0]   modeReg [NCH];
  logic [1:0]   modeNext [NCH];
  logic [N-1:0] readNext;

  logic [11:0]    regIdx;
  logic           hostWrEn, ctrlWr, advance;
  logic           haltReq, stepReq, resumeReq;
  logic [N-1:0]   cycleInc;
  logic [NCH-1:0] hit;
  logic [NCH:0]   clearMask;
  logic           unusedAddrBits;

  function automatic logic [11:0] chanAddr(input int unsigned k, input int unsigned sub);
    return 12'(32'h100 + 4 * k + sub);
  endfunction

  // Address bits above the 4K window are not decoded.
  assign unusedAddrBits = ^coprocessorIOAddr[14:13];

  assign regIdx     = coprocessorIOAddr[11:0];
  assign hostWrEn   = hostWrite & debugEnable & coprocessorIOAddr[12];
  assign ctrlWr     = hostWrEn && (regIdx == 12'h000);
  assign haltReq    = ctrlWr & coprocessorIODataOut[2];
  assign stepReq    = ctrlWr & coprocessorIODataOut[1];
  assign resumeReq  = ctrlWr & coprocessorIODataOut[0];
  assign coreStall  = hostFreeze | (state == HALTED);
  assign haltedFlag = (state == HALTED);
  assign debugFlags = status;
  assign advance    = ~coreStall;
  assign cycleInc   = cycleCount + N'(1);

  // Channels: hit-driven update first, a host write to the same register wins.
  always_comb begin
    compareNext = compareReg;
    periodNext  = periodReg;
    modeNext    = modeReg;
    hit         = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      hit[k] = debugEnable && (modeReg[k] != 2'b00) && advance && (cycleInc == compareReg[k]);
      if (hit[k]) begin
        if (modeReg[k] == 2'b10) modeNext[k] = 2'b00;
        else if (modeReg[k] == 2'b11) compareNext[k] = compareReg[k] + periodReg[k];
      end
      if (hostWrEn && (regIdx == chanAddr(k, 0))) compareNext[k] = coprocessorIODataOut;
      if (hostWrEn && (regIdx == chanAddr(k, 1))) periodNext[k]  = coprocessorIODataOut;
      if (hostWrEn && (regIdx == chanAddr(k, 2))) modeNext[k]    = coprocessorIODataOut[1:0];
    end
  end

  always_comb begin
    cycleNext = cycleCount;
    if (advance) cycleNext = cycleInc;
    if (hostWrEn && (regIdx == 12'h002)) cycleNext = coprocessorIODataOut;
  end

  // Sticky flags: new sets survive a same-edge write-1-to-clear.
  always_comb begin
    clearMask = '0;
    if (hostWrEn && (regIdx == 12'h001)) clearMask = FW'(coprocessorIODataOut);
    statusNext = (status & ~clearMask) | {hit, ebreakSignal & debugEnable};
  end

  assign haltOnEbreakNext = ctrlWr ? coprocessorIODataOut[3] : haltOnEbreak;

  always_comb begin
    stateNext = state;
    if (!debugEnable) begin
      stateNext = RUN;
    end else begin
      case (state)
        RUN:     if ((|hit) || haltReq || (ebreakSignal && haltOnEbreak)) stateNext = HALTED;
        HALTED:  if (haltReq) stateNext = HALTED;
                 else if (stepReq) stateNext = STEP;
                 else if (resumeReq) stateNext = RUN;
        STEP:    stateNext = HALTED;
        default: stateNext = RUN;
      endcase
    end
  end

  // Read data is muxed from next-state values so it reflects this edge's updates.
  always_comb begin
    readNext = '0;
    if (coprocessorIOAddr[12]) begin
      if (regIdx == 12'h000) readNext = N'({haltOnEbreakNext, stateNext});
      else if (regIdx == 12'h001) readNext = N'(statusNext);
      else if (regIdx == 12'h002) readNext = cycleNext;
      for (int unsigned k = 0; k < NCH; k++) begin
        if (regIdx == chanAddr(k, 0)) readNext = compareNext[k];
        if (regIdx == chanAddr(k, 1)) readNext = periodNext[k];
        if (regIdx == chanAddr(k, 2)) readNext = N'(modeNext[k]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= RUN;
      haltOnEbreak        <= 1'b0;
      status              <= '0;
      cycleCount          <= '0;
      coprocessorIODataIn <= '0;
      for (int unsigned k = 0; k < NCH; k++) begin
        compareReg[k] <= '0;
        periodReg[k]  <= '0;
        modeReg[k]    <= '0;
      end
    end else begin
      state               <= stateNext;
      haltOnEbreak        <= haltOnEbreakNext;
      status              <= statusNext;
      cycleCount          <= cycleNext;
      coprocessorIODataIn <= readNext;
      compareReg          <= compareNext;
      periodReg           <= periodNext;
      modeReg             <= modeNext;
    end
  end

endmodule
